// File: rtl/dataflow_pkg.sv
// Shared constants for dataflow_node: operator names and opcodes, fan-in/fan-out
// limits and the width of the fire counter.
package dataflow_pkg;

  localparam int MAX_INPUT_SIZE   = 3;
  localparam int MAX_OUTPUT_SIZE  = 8;
  localparam int FIRE_COUNT_WIDTH = 32;

  localparam string OP_REG  = "reg";
  localparam string OP_IN   = "in";
  localparam string OP_OUT  = "out";
  localparam string OP_ADD  = "add";
  localparam string OP_SUB  = "sub";
  localparam string OP_MUL  = "mul";
  localparam string OP_ADDI = "addi";
  localparam string OP_SUBI = "subi";
  localparam string OP_MULI = "muli";

  typedef enum logic [3:0] {
    OPC_PASS,
    OPC_ADD,
    OPC_SUB,
    OPC_MUL,
    OPC_ADDI,
    OPC_SUBI,
    OPC_MULI
  } opcode_e;

endpackage

// File: rtl/dataflow_node_fifo.sv
// Synchronous DEPTH-entry operand FIFO; a push while full is dropped.
// count_next_o is the occupancy after this edge, used to register the producer request.
module dataflow_node_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2,
  parameter int CW         = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [CW-1:0]         count_next_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q, count_d;
  logic                  push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign count_d = count_q + CW'(push_ok) - CW'(pop_ok);
  assign count_next_o = count_d;
  assign data_o  = mem_q[rd_ptr_q];

  // NOTE: storage is deliberately not reset; count_q alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/dataflow_node.sv
// Dataflow operator with per-input FIFOs and independent per-output delivery.
// Optional macro DATAFLOW_NODE_STATS_EN builds the fire_count register; otherwise it reads 0.
module dataflow_node
  import dataflow_pkg::*;
#(
  parameter int    DATA_WIDTH  = 32,
  parameter string OP          = "reg",
  parameter int    IMMEDIATE   = 0,
  parameter int    INPUT_SIZE  = 1,
  parameter int    OUTPUT_SIZE = 1,
  parameter int    DEPTH       = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  output logic [INPUT_SIZE-1:0]            req_l,
  input  logic [INPUT_SIZE-1:0]            ack_l,
  input  logic [DATA_WIDTH*INPUT_SIZE-1:0] din,
  input  logic [OUTPUT_SIZE-1:0]           req_r,
  output logic [OUTPUT_SIZE-1:0]           ack_r,
  output logic [DATA_WIDTH-1:0]            dout,
  output logic [FIRE_COUNT_WIDTH-1:0]      fire_count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam opcode_e OPC =
      (OP == OP_ADD)  ? OPC_ADD  :
      (OP == OP_SUB)  ? OPC_SUB  :
      (OP == OP_MUL)  ? OPC_MUL  :
      (OP == OP_ADDI) ? OPC_ADDI :
      (OP == OP_SUBI) ? OPC_SUBI :
      (OP == OP_MULI) ? OPC_MULI : OPC_PASS;
  localparam logic [DATA_WIDTH-1:0] IMM_W = DATA_WIDTH'(IMMEDIATE);

  logic [DATA_WIDTH-1:0]  operand [INPUT_SIZE];
  logic [CW-1:0]          count_next [INPUT_SIZE];
  logic [INPUT_SIZE-1:0]  fifo_empty, fifo_full, req_l_q, req_l_d;
  logic [OUTPUT_SIZE-1:0] pending_q, ack_r_q, ack_r_d;
  logic [DATA_WIDTH-1:0]  dout_q, result, sum, diff, prod;
  logic                   fire;

  for (genvar i = 0; i < INPUT_SIZE; i++) begin : g_in
    dataflow_node_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .CW(CW)) u_fifo (
      .clk          (clk),
      .rst          (rst),
      .push_i       (ack_l[i] & ~fifo_full[i]),
      .data_i       (din[DATA_WIDTH*i +: DATA_WIDTH]),
      .pop_i        (fire),
      .data_o       (operand[i]),
      .full_o       (fifo_full[i]),
      .empty_o      (fifo_empty[i]),
      .count_next_o (count_next[i])
    );
  end

  // A new result may only be produced once every consumer has taken the old one.
  assign fire    = ~|fifo_empty & ~|pending_q & ~|ack_r_q;
  assign ack_r_d = pending_q & req_r & ~ack_r_q;

  always_comb begin
    // NOTE: combinational blocks use blocking assignments and give every variable
    // a default first, so the loop accumulates correctly and no latch is inferred.
    sum  = operand[0];
    diff = operand[0];
    prod = operand[0];
    for (int i = 1; i < INPUT_SIZE; i++) begin
      sum  = sum + operand[i];
      diff = diff - operand[i];
      prod = prod * operand[i];
    end
    case (OPC)
      OPC_ADD:  result = sum;
      OPC_SUB:  result = diff;
      OPC_MUL:  result = prod;
      OPC_ADDI: result = operand[0] + IMM_W;
      OPC_SUBI: result = operand[0] - IMM_W;
      OPC_MULI: result = operand[0] * IMM_W;
      default:  result = operand[0];
    endcase
  end

  always_comb begin
    req_l_d = '0;
    for (int i = 0; i < INPUT_SIZE; i++) req_l_d[i] = (count_next[i] < CW'(DEPTH));
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst) begin
      req_l_q   <= '0;
      ack_r_q   <= '0;
      pending_q <= '0;
      dout_q    <= '0;
    end else begin
      req_l_q <= req_l_d;
      ack_r_q <= ack_r_d;
      if (fire) begin
        dout_q    <= result;
        pending_q <= '1;
      end else begin
        pending_q <= pending_q & ~ack_r_d;
      end
    end
  end

  assign req_l = req_l_q;
  assign ack_r = ack_r_q;
  assign dout  = dout_q;

`ifdef DATAFLOW_NODE_STATS_EN
  logic [FIRE_COUNT_WIDTH-1:0] fire_count_q;

  always_ff @(posedge clk) begin
    if (!rst)      fire_count_q <= '0;
    else if (fire) fire_count_q <= fire_count_q + 1'b1;
  end

  assign fire_count = fire_count_q;
`else
  assign fire_count = '0;
`endif

endmodule

// File: tb/tb_dataflow_node.sv
// Directed self-checking bench for dataflow_node: reset, arithmetic, wrap,
// backpressure, fan-out and fire counting across several parameterisations.
module tb_dataflow_node;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int viol     = 0;

`ifdef DATAFLOW_NODE_STATS_EN
  localparam logic [31:0] STATS_MASK = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] STATS_MASK = 32'h0;
`endif

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_fc(input int n);
    return 32'(n) & STATS_MASK;
  endfunction

  // backpressure / reset: reg, W=8, 1 in, 1 out, DEPTH=2
  logic [0:0] bp_req_l, bp_ack_l, bp_req_r, bp_ack_r;
  logic [7:0] bp_din, bp_dout;
  logic [31:0] bp_fc;
  dataflow_node #(.DATA_WIDTH(8), .OP("reg"), .INPUT_SIZE(1), .OUTPUT_SIZE(1), .DEPTH(2)) u_bp (
    .clk(clk), .rst(rst), .req_l(bp_req_l), .ack_l(bp_ack_l), .din(bp_din),
    .req_r(bp_req_r), .ack_r(bp_ack_r), .dout(bp_dout), .fire_count(bp_fc));

  // add, W=32, 2 in, 1 out
  logic [1:0]  ad_req_l, ad_ack_l;
  logic [0:0]  ad_req_r, ad_ack_r;
  logic [63:0] ad_din;
  logic [31:0] ad_dout, ad_fc;
  dataflow_node #(.DATA_WIDTH(32), .OP("add"), .INPUT_SIZE(2), .OUTPUT_SIZE(1)) u_add (
    .clk(clk), .rst(rst), .req_l(ad_req_l), .ack_l(ad_ack_l), .din(ad_din),
    .req_r(ad_req_r), .ack_r(ad_ack_r), .dout(ad_dout), .fire_count(ad_fc));

  // sub, W=8, 2 in
  logic [1:0]  sb_req_l, sb_ack_l;
  logic [0:0]  sb_req_r, sb_ack_r;
  logic [15:0] sb_din;
  logic [7:0]  sb_dout;
  logic [31:0] sb_fc;
  dataflow_node #(.DATA_WIDTH(8), .OP("sub"), .INPUT_SIZE(2), .OUTPUT_SIZE(1)) u_sub (
    .clk(clk), .rst(rst), .req_l(sb_req_l), .ack_l(sb_ack_l), .din(sb_din),
    .req_r(sb_req_r), .ack_r(sb_ack_r), .dout(sb_dout), .fire_count(sb_fc));

  // muli, W=8, IMMEDIATE=3
  logic [0:0]  mi_req_l, mi_ack_l, mi_req_r, mi_ack_r;
  logic [7:0]  mi_din, mi_dout;
  logic [31:0] mi_fc;
  dataflow_node #(.DATA_WIDTH(8), .OP("muli"), .IMMEDIATE(3), .INPUT_SIZE(1), .OUTPUT_SIZE(1)) u_muli (
    .clk(clk), .rst(rst), .req_l(mi_req_l), .ack_l(mi_ack_l), .din(mi_din),
    .req_r(mi_req_r), .ack_r(mi_ack_r), .dout(mi_dout), .fire_count(mi_fc));

  // fan-out: reg, W=16, 3 outputs
  logic [0:0]  fo_req_l, fo_ack_l;
  logic [2:0]  fo_req_r, fo_ack_r;
  logic [15:0] fo_din, fo_dout;
  logic [31:0] fo_fc;
  dataflow_node #(.DATA_WIDTH(16), .OP("reg"), .INPUT_SIZE(1), .OUTPUT_SIZE(3)) u_fan (
    .clk(clk), .rst(rst), .req_l(fo_req_l), .ack_l(fo_ack_l), .din(fo_din),
    .req_r(fo_req_r), .ack_r(fo_ack_r), .dout(fo_dout), .fire_count(fo_fc));

  // stats: addi, W=16, IMMEDIATE=7, DEPTH=4
  logic [0:0]  st_req_l, st_ack_l, st_req_r, st_ack_r;
  logic [15:0] st_din, st_dout;
  logic [31:0] st_fc;
  dataflow_node #(.DATA_WIDTH(16), .OP("addi"), .IMMEDIATE(7), .INPUT_SIZE(1), .OUTPUT_SIZE(1), .DEPTH(4)) u_st (
    .clk(clk), .rst(rst), .req_l(st_req_l), .ack_l(st_ack_l), .din(st_din),
    .req_r(st_req_r), .ack_r(st_ack_r), .dout(st_dout), .fire_count(st_fc));

  // A push while the producer request is low would land in a full FIFO.
  always @(posedge clk) begin
    if (rst === 1'b1) begin
      if (|(bp_ack_l & ~bp_req_l)) viol++;
      if (|(ad_ack_l & ~ad_req_l)) viol++;
      if (|(sb_ack_l & ~sb_req_l)) viol++;
      if (|(mi_ack_l & ~mi_req_l)) viol++;
      if (|(fo_ack_l & ~fo_req_l)) viol++;
      if (|(st_ack_l & ~st_req_l)) viol++;
    end
  end

  initial begin
    int seen;
    int got_n;
    logic [7:0] bp_exp [3];
    logic stable;

    rst = 1'b0;
    bp_ack_l = '0; bp_din = '0; bp_req_r = '0;
    ad_ack_l = '0; ad_din = '0; ad_req_r = '0;
    sb_ack_l = '0; sb_din = '0; sb_req_r = '0;
    mi_ack_l = '0; mi_din = '0; mi_req_r = '0;
    fo_ack_l = '0; fo_din = '0; fo_req_r = '0;
    st_ack_l = '0; st_din = '0; st_req_r = '0;
    repeat (3) @(negedge clk);
    check("init_req_l", bp_req_l, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("req_l_after_reset", bp_req_l, 1'b1);

    // Reset mid-flight: one result pending, two tokens left in the FIFO.
    bp_ack_l = 1'b1; bp_din = 8'd1;
    @(negedge clk); bp_din = 8'd2;
    @(negedge clk); bp_din = 8'd3;
    @(negedge clk); bp_ack_l = 1'b0;
    check("midflight_full", bp_req_l, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("rst_req_l", bp_req_l, 1'b0);
    check("rst_ack_r", bp_ack_r, 1'b0);
    check("rst_dout", bp_dout, 8'd0);
    check("rst_fire_count", bp_fc, 32'd0);
    bp_req_r = 1'b1;
    seen = 0;
    stable = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (bp_ack_r[0]) seen++;
      if (bp_dout != 8'd0) stable = 1'b0;
    end
    check("rst_fifo_empty_acks", seen, 0);
    check("rst_fifo_empty_dout", stable, 1'b1);
    check("rst_req_l_recovers", bp_req_l, 1'b1);
    bp_req_r = 1'b0;

    // Backpressure: consumer stalled, 10 fires, 11 and 12 fill the FIFO.
    bp_ack_l = 1'b1; bp_din = 8'd10;
    @(negedge clk); bp_din = 8'd11;
    @(negedge clk); bp_din = 8'd12;
    @(negedge clk); bp_ack_l = 1'b0;
    check("bp_req_l_low", bp_req_l, 1'b0);
    check("bp_pending_dout", bp_dout, 8'd10);
    repeat (3) @(negedge clk);
    check("bp_req_l_held", bp_req_l, 1'b0);
    bp_exp[0] = 8'd10; bp_exp[1] = 8'd11; bp_exp[2] = 8'd12;
    bp_req_r = 1'b1;
    got_n = 0;
    for (int c = 0; c < 30 && got_n < 3; c++) begin
      @(negedge clk);
      if (bp_ack_r[0]) begin
        check($sformatf("bp_drain%0d", got_n), bp_dout, bp_exp[got_n]);
        got_n++;
      end
    end
    check("bp_drain_count", got_n, 3);
    check("bp_req_l_reopen", bp_req_l, 1'b1);
    bp_req_r = 1'b0;

    // add: 5 + 7, result two cycles after the last operand ack.
    ad_req_r = 1'b1;
    ad_ack_l = 2'b01; ad_din = {32'd0, 32'd5};
    @(negedge clk); ad_ack_l = 2'b10; ad_din = {32'd7, 32'd0};
    @(negedge clk); ad_ack_l = 2'b00;
    check("add_not_early", ad_dout, 32'd0);
    @(negedge clk);
    check("add_result", ad_dout, 32'd12);
    check("add_ack_not_yet", ad_ack_r, 1'b0);
    @(negedge clk);
    check("add_ack_pulse", ad_ack_r, 1'b1);
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (ad_ack_r[0]) seen++;
    end
    check("add_single_ack", seen, 0);

    // Modular wrap: 3 - 5 in 8 bits, and 100 * 3 in 8 bits.
    sb_req_r = 1'b1; mi_req_r = 1'b1;
    sb_ack_l = 2'b11; sb_din = {8'd5, 8'd3};
    mi_ack_l = 1'b1;  mi_din = 8'd100;
    @(negedge clk); sb_ack_l = 2'b00; mi_ack_l = 1'b0;
    @(negedge clk);
    check("sub_wrap", sb_dout, 8'd254);
    check("muli_wrap", mi_dout, 8'd44);

    // Fan-out: outputs 0/1 ready at once, output 2 twenty cycles later.
    fo_req_r = 3'b011;
    fo_ack_l = 1'b1; fo_din = 16'hAAAA;
    @(negedge clk); fo_din = 16'h5555;
    @(negedge clk); fo_ack_l = 1'b0;
    check("fo_first_result", fo_dout, 16'hAAAA);
    @(negedge clk);
    check("fo_fast_acks", fo_ack_r, 3'b011);
    stable = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (fo_dout != 16'hAAAA) stable = 1'b0;
      if (fo_ack_r[0]) seen++;
    end
    check("fo_dout_stable", stable, 1'b1);
    check("fo_no_refire", seen, 0);
    fo_req_r = 3'b111;
    seen = 0;
    for (int c = 0; c < 10 && seen == 0; c++) begin
      @(negedge clk);
      if (fo_ack_r[2]) begin
        seen = 1;
        check("fo_slow_ack_dout", fo_dout, 16'hAAAA);
      end
    end
    check("fo_slow_ack_seen", seen, 1);
    seen = 0;
    for (int c = 0; c < 10 && seen == 0; c++) begin
      @(negedge clk);
      if (fo_ack_r[0]) begin
        seen = 1;
        check("fo_second_result", fo_dout, 16'h5555);
      end
    end
    check("fo_second_seen", seen, 1);

    // Stream 5000 tokens through addi with a ready consumer.
    st_req_r = 1'b1;
    fork
      begin
        int sent;
        sent = 0;
        for (int c = 0; c < 40000 && sent < 5000; c++) begin
          @(negedge clk);
          if (st_req_l[0]) begin
            st_ack_l = 1'b1;
            st_din = 16'(sent);
            sent++;
          end else begin
            st_ack_l = 1'b0;
          end
        end
        @(negedge clk);
        st_ack_l = 1'b0;
      end
      begin
        int rcvd;
        rcvd = 0;
        for (int c = 0; c < 40000 && rcvd < 5000; c++) begin
          @(negedge clk);
          if (st_ack_r[0]) begin
            check("st_value", st_dout, 16'(rcvd + 7));
            rcvd++;
          end
        end
        check("st_received", rcvd, 5000);
      end
    join
    repeat (4) @(negedge clk);

    check("fc_stats", st_fc, exp_fc(5000));
    check("fc_add", ad_fc, exp_fc(1));
    check("fc_bp", bp_fc, exp_fc(3));
    check("fc_fan", fo_fc, exp_fc(2));
    check("fc_sub", sb_fc, exp_fc(1));
    check("proto_violations", viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dataflow_node.md
# dataflow_node

Parametrised successor to the single-register dataflow operator used in the ARF graphs. It receives operands over per-input req/ack channels into per-input FIFOs, fires one operation when every FIFO holds an operand, and delivers the result independently to each fan-out consumer with a per-output ack. A fast consumer therefore no longer waits on a slow sibling, and producers can run ahead by `DEPTH` tokens.

## Interface
Parameters:
- `DATA_WIDTH`, 32: operand and result width.
- `OP`, "reg": one of reg, in, out, add, sub, mul, addi, subi, muli.
- `IMMEDIATE`, 0: constant used by the addi, subi and muli ops.
- `INPUT_SIZE`, 1: number of operand channels, 1..3.
- `OUTPUT_SIZE`, 1: number of fan-out consumers, 1..8.
- `DEPTH`, 2: entries per input FIFO; a power of two, at least 2.

Ports (one clock; reset is synchronous and active-low):
- `clk`, input, 1: clock; all logic on the rising edge.
- `rst`, input, 1: synchronous, active-low reset.
- `req_l`, output, `INPUT_SIZE`: request to each operand producer.
- `ack_l`, input, `INPUT_SIZE`: producer ack pulse; the matching din slice is valid in the same cycle.
- `din`, input, `DATA_WIDTH*INPUT_SIZE`: operands; operand i is slice [W*(i+1)-1 : W*i].
- `req_r`, input, `OUTPUT_SIZE`: request from each consumer.
- `ack_r`, output, `OUTPUT_SIZE`: per-consumer delivery pulse.
- `dout`, output, `DATA_WIDTH`: result register.
- `fire_count`, output, 32: number of operations fired.

## Operation
Reset (`rst`=0 at a clock edge):
- All FIFOs are emptied and `pending` is cleared.
- `req_l`, `ack_r`, `dout` and `fire_count` are all 0.
- Reset asserted mid-transfer discards any in-flight tokens; there is no partial delivery.

Input channel i:
- `req_l[i]` is registered. Its next value is 1 when count_next[i] < `DEPTH`, otherwise 0.
- count_next[i] accounts for this cycle's push and pop.
- On an edge with `ack_l[i]`=1, din slice i is pushed into FIFO i.
- Data is sampled synchronously on `clk`, never on an `ack_l` edge.
- A push and a pop on the same edge leave the count unchanged.
- If `ack_l[i]` arrives while FIFO i is full, the token is dropped. This is a protocol violation; the bench asserts on it.

Fire condition, evaluated each edge: every FIFO is non-empty, `pending`==0, and `ack_r`==0. When it holds:
- One entry is popped from every FIFO.
- `dout` is loaded with the operator result.
- `pending` is set to all ones.
- `fire_count` is incremented.

Output j:
- When `pending[j]`=1, `req_r[j]`=1 and `ack_r[j]`=0, the node drives `ack_r[j]`=1 for exactly one cycle and clears `pending[j]`.
- Each output is independent of the others.
- `dout` is held constant from the fire until the last `ack_r` pulse has been seen.

Arithmetic:
- All results are taken modulo 2^`DATA_WIDTH`; mul keeps the low W bits.
- sub computes op0−op1−op2.
- addi, subi and muli apply `IMMEDIATE` to op0.
- reg, in and out pass op0 through unchanged.

## Timing
- Operand to result: the edge that pushes the last missing operand is followed by the fire on the next edge. `dout` is valid 2 cycles after that `ack_l`.
- Result to consumer: `ack_r[j]` rises at the earliest on the edge after the fire, provided `req_r[j]` is held.
- Next fire: no earlier than one cycle after the final `ack_r` pulse falls. Peak throughput is one result per 3 cycles with all consumers ready.
- `req_l` drops on the edge where the FIFO becomes full. It rises on the edge after a pop frees an entry.

## Configuration
- Macro `DATAFLOW_NODE_STATS_EN`.
- Defined: `fire_count` increments on every fire and wraps at 2^32.
- Undefined: `fire_count` is tied to 0 and the counter register is not built.

## Structure
- Package `dataflow_pkg`: the op-name constants, the `INPUT_SIZE` and `OUTPUT_SIZE` limits, and the `fire_count` width.
- Sub-module `dataflow_node_fifo`:
  - Synchronous, `DEPTH`-entry FIFO with push, pop, full, empty and count.
  - Generated once per input.
- The top level holds the fire logic, the result register, `pending` and the ack generation.

## Test plan
- Reset mid-flight: fill FIFO 0 with 2 tokens, then assert `rst`=0 for one cycle → `req_l`, `ack_r`, `dout` and `fire_count` read 0, and the FIFOs are empty.
- add, `INPUT_SIZE`=2, `OUTPUT_SIZE`=1: push op0=5 and op1=7 → `dout`=12 two cycles after the last ack, then exactly one `ack_r` pulse.
- Wrap: sub with `DATA_WIDTH`=8, op0=3, op1=5 → `dout`=254. muli with `IMMEDIATE`=3 and op0=100 → `dout`=44.
- Backpressure: `DEPTH`=2, consumer holds `req_r`=0, producer pushes 10,11,12 → the FIFO fills after the pending result and `req_l` goes low; releasing `req_r` drains 10, 11, 12 in order.
- Fan-out, `OUTPUT_SIZE`=3: consumer 0 ready immediately, consumer 2 ready 20 cycles later → `ack_r[0]` fires at once, `dout` is stable until `ack_r[2]`, and no second fire happens before it.
- Stats: with `DATAFLOW_NODE_STATS_EN` defined, 5000 tokens through addi → `fire_count`=5000 and the values are correct. With the macro undefined, `fire_count` stays 0.
